// File: rtl/axil_ctrl_slave_pkg.sv
// ============================================================================
// Module      : axil_ctrl_pkg
// Description : Shared definitions for the axil_ctrl_slave register block:
//               register byte addresses, AXI response code, channel FSM state
//               types, register-select type and the byte-strobe merge helper.
// Ports       : none (package)
// Options     : AXIL_CTRL_IRQ_EN enables the GIE/IER/ISR registers in the
//               top level; the addresses below are always defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axil_ctrl_pkg;

  // Bus data width; the register file is 32 bits wide by construction.
  localparam int AXIL_DATA_W = 32;

  // Register byte addresses
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_GIE    = 8'h04;
  localparam logic [7:0] ADDR_IER    = 8'h08;
  localparam logic [7:0] ADDR_ISR    = 8'h0C;
  localparam logic [7:0] ADDR_ERR    = 8'h10;
  localparam logic [7:0] ADDR_FRAMES = 8'h20;
  localparam logic [7:0] ADDR_OFFSET = 8'h28;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_CTRL   = 3'd1,
    SEL_GIE    = 3'd2,
    SEL_IER    = 3'd3,
    SEL_ISR    = 3'd4,
    SEL_ERR    = 3'd5,
    SEL_FRAMES = 3'd6,
    SEL_OFFSET = 3'd7
  } reg_sel_e;

  // Replace only the bytes whose strobe is set.
  function automatic logic [AXIL_DATA_W-1:0] strb_merge(
    input logic [AXIL_DATA_W-1:0]   old_v,
    input logic [AXIL_DATA_W-1:0]   new_v,
    input logic [AXIL_DATA_W/8-1:0] strb
  );
    logic [AXIL_DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < AXIL_DATA_W/8; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_v[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axil_ctrl_slave_if.sv
// ============================================================================
// Module      : axil_ctrl_slave_if
// Description : AXI4-Lite bus bundle between the control master and the
//               axil_ctrl_slave register block.
// Ports       : awaddr/awvalid/awready, wdata/wstrb/wvalid/wready,
//               bresp/bvalid/bready, araddr/arvalid/arready,
//               rdata/rresp/rvalid/rready
// Modports    : master (drives requests), slave (drives responses)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axil_ctrl_slave_if #(
  parameter int ADDR_W = 6
) ();
  import axil_ctrl_pkg::*;

  logic [ADDR_W-1:0]        awaddr;
  logic                     awvalid;
  logic                     awready;
  logic [AXIL_DATA_W-1:0]   wdata;
  logic [AXIL_DATA_W/8-1:0] wstrb;
  logic                     wvalid;
  logic                     wready;
  logic [1:0]               bresp;
  logic                     bvalid;
  logic                     bready;
  logic [ADDR_W-1:0]        araddr;
  logic                     arvalid;
  logic                     arready;
  logic [AXIL_DATA_W-1:0]   rdata;
  logic [1:0]               rresp;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );

endinterface

`default_nettype wire

// File: rtl/axil_ctrl_slave.sv
// ============================================================================
// Module      : axil_ctrl_slave
// Description : AXI4-Lite control/status register file of a streaming
//               accelerator core. Map: 0x00 ctrl (ap_start/done/idle/ready),
//               0x10 error_num (RO), 0x20 test_frame_num, 0x28 frame_offset.
//               Optional 0x04 GIE, 0x08 IER, 0x0C ISR with AXIL_CTRL_IRQ_EN.
// Ports       : clk_0, sync_rst_0 (sync, active-high)
//               s_axi          - AXI4-Lite slave bundle
//               ap_start       - start request to core (cleared by ap_ready)
//               ap_done/ap_idle/ap_ready - core block-level status
//               error_num_i    - core error count, captured on ap_done
//               test_frame_num, frame_offset - RW configuration outputs
//               interrupt      - only when AXIL_CTRL_IRQ_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_ctrl_slave
  import axil_ctrl_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk_0,
  input  logic              sync_rst_0,
  axil_ctrl_slave_if.slave  s_axi,
  output logic              ap_start,
  input  logic              ap_done,
  input  logic              ap_idle,
  input  logic              ap_ready,
  input  logic [DATA_W-1:0] error_num_i,
  output logic [DATA_W-1:0] test_frame_num,
  output logic [DATA_W-1:0] frame_offset
`ifdef AXIL_CTRL_IRQ_EN
  ,
  output logic              interrupt
`endif
);

  // Word-aligned decode constants (byte address bits [1:0] are ignored)
  localparam logic [ADDR_W-3:0] c_W_CTRL   = (ADDR_W-2)'(ADDR_CTRL >> 2);
  localparam logic [ADDR_W-3:0] c_W_ERR    = (ADDR_W-2)'(ADDR_ERR >> 2);
  localparam logic [ADDR_W-3:0] c_W_FRAMES = (ADDR_W-2)'(ADDR_FRAMES >> 2);
  localparam logic [ADDR_W-3:0] c_W_OFFSET = (ADDR_W-2)'(ADDR_OFFSET >> 2);
`ifdef AXIL_CTRL_IRQ_EN
  localparam logic [ADDR_W-3:0] c_W_GIE    = (ADDR_W-2)'(ADDR_GIE >> 2);
  localparam logic [ADDR_W-3:0] c_W_IER    = (ADDR_W-2)'(ADDR_IER >> 2);
  localparam logic [ADDR_W-3:0] c_W_ISR    = (ADDR_W-2)'(ADDR_ISR >> 2);
`endif

  // Without the interrupt option the GIE/IER/ISR words decode as unmapped,
  // so they read as zero and ignore writes.
  function automatic reg_sel_e sel_of(input logic [ADDR_W-3:0] word);
    reg_sel_e s;
    s = SEL_NONE;
    if (word == c_W_CTRL)   s = SEL_CTRL;
    if (word == c_W_ERR)    s = SEL_ERR;
    if (word == c_W_FRAMES) s = SEL_FRAMES;
    if (word == c_W_OFFSET) s = SEL_OFFSET;
`ifdef AXIL_CTRL_IRQ_EN
    if (word == c_W_GIE)    s = SEL_GIE;
    if (word == c_W_IER)    s = SEL_IER;
    if (word == c_W_ISR)    s = SEL_ISR;
`endif
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Write channel state
  // --------------------------------------------------------------------------
  wr_state_e           r_wr_state;
  logic                r_aw_latched;
  logic                r_w_latched;
  logic                r_awready;
  logic                r_wready;
  logic                r_bvalid;
  logic [ADDR_W-3:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;

  // --------------------------------------------------------------------------
  // Read channel state
  // --------------------------------------------------------------------------
  rd_state_e           r_rd_state;
  logic                r_arready;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rd_is_ctrl;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic                r_ap_start;
  logic                r_done_sticky;
  logic [DATA_W-1:0]   r_error_num;
  logic [DATA_W-1:0]   r_test_frame_num;
  logic [DATA_W-1:0]   r_frame_offset;

  logic                w_wr_commit;
  reg_sel_e            w_wr_sel;
  reg_sel_e            w_rd_sel;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_start_set;
  logic                w_done_clr;

  // Both halves of the write are held for one cycle before the update so the
  // register file sees a single, stable address/data/strobe set.
  assign w_wr_commit = (r_wr_state == WR_IDLE) && r_aw_latched && r_w_latched;
  assign w_wr_sel    = sel_of(r_awaddr);
  assign w_rd_sel    = sel_of(s_axi.araddr[ADDR_W-1:2]);
  assign w_start_set = w_wr_commit && (w_wr_sel == SEL_CTRL) && r_wstrb[0] && r_wdata[0];
  // The sticky done bit is consumed only when a ctrl read actually completes.
  assign w_done_clr  = (r_rd_state == RD_DATA) && s_axi.rready && r_rd_is_ctrl;

`ifdef AXIL_CTRL_IRQ_EN
  logic       r_gie;
  logic [1:0] r_ier;
  logic [1:0] r_isr;
  logic       r_irq;
  logic [1:0] w_isr_set;
  logic [1:0] w_isr_tog;

  assign w_isr_set = {ap_ready & r_ier[1], ap_done & r_ier[0]};
  assign w_isr_tog = (w_wr_commit && (w_wr_sel == SEL_ISR) && r_wstrb[0]) ?
                     r_wdata[1:0] : 2'b00;
  assign interrupt = r_irq;
`endif

  // Read data multiplexer; live core status bits are sampled at AR accept.
  always_comb begin
    w_rd_data = '0;
    case (w_rd_sel)
      SEL_CTRL:   w_rd_data = {{(DATA_W-4){1'b0}}, ap_ready, ap_idle, r_done_sticky, r_ap_start};
      SEL_ERR:    w_rd_data = r_error_num;
      SEL_FRAMES: w_rd_data = r_test_frame_num;
      SEL_OFFSET: w_rd_data = r_frame_offset;
`ifdef AXIL_CTRL_IRQ_EN
      SEL_GIE:    w_rd_data = {{(DATA_W-1){1'b0}}, r_gie};
      SEL_IER:    w_rd_data = {{(DATA_W-2){1'b0}}, r_ier};
      SEL_ISR:    w_rd_data = {{(DATA_W-2){1'b0}}, r_isr};
`endif
      default:    w_rd_data = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Write FSM: AW and W are captured independently, then committed together.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_0) begin
    if (sync_rst_0) begin
      r_wr_state   <= WR_IDLE;
      r_aw_latched <= 1'b0;
      r_w_latched  <= 1'b0;
      r_awready    <= 1'b0;
      r_wready     <= 1'b0;
      r_bvalid     <= 1'b0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          if (r_aw_latched && r_w_latched) begin
            r_bvalid   <= 1'b1;
            r_wr_state <= WR_RESP;
          end else begin
            if (s_axi.awvalid && r_awready) begin
              r_awaddr     <= s_axi.awaddr[ADDR_W-1:2];
              r_aw_latched <= 1'b1;
              r_awready    <= 1'b0;
            end else begin
              r_awready    <= !r_aw_latched;
            end
            if (s_axi.wvalid && r_wready) begin
              r_wdata     <= s_axi.wdata;
              r_wstrb     <= s_axi.wstrb;
              r_w_latched <= 1'b1;
              r_wready    <= 1'b0;
            end else begin
              r_wready    <= !r_w_latched;
            end
          end
        end
        WR_RESP: begin
          if (s_axi.bready) begin
            r_bvalid     <= 1'b0;
            r_aw_latched <= 1'b0;
            r_w_latched  <= 1'b0;
            r_awready    <= 1'b1;
            r_wready     <= 1'b1;
            r_wr_state   <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM: data is captured at AR accept and held until R handshake.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_0) begin
    if (sync_rst_0) begin
      r_rd_state   <= RD_IDLE;
      r_arready    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_rd_is_ctrl <= 1'b0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (r_arready && s_axi.arvalid) begin
            r_rdata      <= w_rd_data;
            r_rvalid     <= 1'b1;
            r_arready    <= 1'b0;
            r_rd_is_ctrl <= (w_rd_sel == SEL_CTRL);
            r_rd_state   <= RD_DATA;
          end else begin
            r_arready    <= 1'b1;
          end
        end
        RD_DATA: begin
          if (s_axi.rready) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= RD_IDLE;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Register updates
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_0) begin
    if (sync_rst_0) begin
      r_ap_start       <= 1'b0;
      r_done_sticky    <= 1'b0;
      r_error_num      <= '0;
      r_test_frame_num <= '0;
      r_frame_offset   <= '0;
`ifdef AXIL_CTRL_IRQ_EN
      r_gie            <= 1'b0;
      r_ier            <= 2'b00;
      r_isr            <= 2'b00;
      r_irq            <= 1'b0;
`endif
    end else begin
      // A software start coinciding with ap_ready must not be lost.
      if (w_start_set) begin
        r_ap_start <= 1'b1;
      end else if (ap_ready) begin
        r_ap_start <= 1'b0;
      end

      // A new done event outranks the clear from a completing ctrl read.
      if (ap_done) begin
        r_done_sticky <= 1'b1;
      end else if (w_done_clr) begin
        r_done_sticky <= 1'b0;
      end

      if (ap_done) begin
        r_error_num <= error_num_i;
      end

      if (w_wr_commit && (w_wr_sel == SEL_FRAMES)) begin
        r_test_frame_num <= strb_merge(r_test_frame_num, r_wdata, r_wstrb);
      end
      if (w_wr_commit && (w_wr_sel == SEL_OFFSET)) begin
        r_frame_offset <= strb_merge(r_frame_offset, r_wdata, r_wstrb);
      end

`ifdef AXIL_CTRL_IRQ_EN
      if (w_wr_commit && (w_wr_sel == SEL_GIE) && r_wstrb[0]) begin
        r_gie <= r_wdata[0];
      end
      if (w_wr_commit && (w_wr_sel == SEL_IER) && r_wstrb[0]) begin
        r_ier <= r_wdata[1:0];
      end
      // New events set bits even when software toggles them in the same cycle.
      r_isr <= (r_isr ^ w_isr_tog) | w_isr_set;
      r_irq <= r_gie & (|r_isr);
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = RESP_OKAY;

  assign ap_start       = r_ap_start;
  assign test_frame_num = r_test_frame_num;
  assign frame_offset   = r_frame_offset;

  // Sub-word address bits carry no meaning for a 32-bit register file.
  logic w_unused;
  assign w_unused = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_axil_ctrl_slave.sv
// ============================================================================
// Module      : tb_axil_ctrl_slave
// Description : Self-checking bench for axil_ctrl_slave (default build):
//               directed handshake/timing sequences, a table of write/read
//               vectors, and a randomized run against a register-map model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_ctrl_slave;

  localparam int ADDR_W = 6;

  logic        clk_0 = 1'b0;
  logic        sync_rst_0;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [31:0] error_num_i;
  logic [31:0] test_frame_num;
  logic [31:0] frame_offset;

  axil_ctrl_slave_if #(.ADDR_W(ADDR_W)) bus ();

  axil_ctrl_slave #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk_0          (clk_0),
    .sync_rst_0     (sync_rst_0),
    .s_axi          (bus),
    .ap_start       (ap_start),
    .ap_done        (ap_done),
    .ap_idle        (ap_idle),
    .ap_ready       (ap_ready),
    .error_num_i    (error_num_i),
    .test_frame_num (test_frame_num),
    .frame_offset   (frame_offset)
  );

  always #5 clk_0 = ~clk_0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_0);
    #1;
  endtask

  // Byte-lane update expressed as a mask over the whole word.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) mask = mask | (32'hFF << (8 * b));
    end
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick(); n++;
      if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin bus.wvalid  = 1'b0; w_done  = 1; end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    while (!bus.bvalid && n < 60) begin tick(); n++; end
    check("wr_bvalid", {31'b0, bus.bvalid}, 32'd1);
    resp = bus.bresp;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic issue_ar(input logic [5:0] addr);
    bit hs;
    int n;
    hs = 0; n = 0;
    bus.araddr = addr; bus.arvalid = 1'b1;
    while (!hs && n < 50) begin
      hs = bus.arready;
      tick(); n++;
    end
    bus.arvalid = 1'b0;
    check("ar_rvalid", {31'b0, bus.rvalid}, 32'd1);
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    issue_ar(addr);
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic wait_wr_ready();
    int n;
    n = 0;
    while (!(bus.awready && bus.wready) && n < 20) begin tick(); n++; end
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic [31:0] exp_frames;
    logic [31:0] exp_offset;
  } vec_t;

  vec_t vecs[10];

  // Reference register-map state for the randomized phase
  logic [31:0] m_frames, m_offset, m_err;
  logic        m_sticky, m_start;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, rd0, wd, exp;
    logic [1:0]  resp;
    logic [5:0]  a;
    logic [3:0]  st;
    int          n, op;

    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
    ap_done = 0; ap_idle = 0; ap_ready = 0; error_num_i = '0;

    // ---------------- reset state ----------------
    sync_rst_0 = 1'b1;
    tick(); tick();
    check("rst_awready", {31'b0, bus.awready}, 0);
    check("rst_wready",  {31'b0, bus.wready}, 0);
    check("rst_arready", {31'b0, bus.arready}, 0);
    check("rst_bvalid",  {31'b0, bus.bvalid}, 0);
    check("rst_rvalid",  {31'b0, bus.rvalid}, 0);
    check("rst_rdata",   bus.rdata, 0);
    check("rst_ap_start", {31'b0, ap_start}, 0);
    check("rst_frames",  test_frame_num, 0);
    check("rst_offset",  frame_offset, 0);
    sync_rst_0 = 1'b0;
    tick();

    // ---------------- AW and W in the same cycle ----------------
    wait_wr_ready();
    bus.awaddr = 6'h28; bus.wdata = 32'd3742; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    tick();
    bus.awvalid = 0; bus.wvalid = 0;
    check("A_bvalid_c1", {31'b0, bus.bvalid}, 0);
    check("A_awready_c1", {31'b0, bus.awready}, 0);
    tick();
    check("A_bvalid_c2", {31'b0, bus.bvalid}, 1);
    check("A_offset", frame_offset, 32'd3742);
    check("A_bresp", {30'b0, bus.bresp}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("A_bvalid_hold", {31'b0, bus.bvalid}, 1);
      check("A_awready_hold", {31'b0, bus.awready}, 0);
    end
    bus.bready = 1;
    tick();
    bus.bready = 0;
    check("A_bvalid_clr", {31'b0, bus.bvalid}, 0);
    check("A_awready_back", {31'b0, bus.awready}, 1);
    axi_read(6'h28, rd, resp);
    check("A_read_offset", rd, 32'd3742);

    // ---------------- W ahead of AW ----------------
    wait_wr_ready();
    bus.wdata = 32'd10; bus.wstrb = 4'hF; bus.wvalid = 1;
    tick();
    bus.wvalid = 0;
    tick();
    check("B_no_bvalid_1", {31'b0, bus.bvalid}, 0);
    tick();
    check("B_no_bvalid_2", {31'b0, bus.bvalid}, 0);
    bus.awaddr = 6'h20; bus.awvalid = 1;
    tick();
    bus.awvalid = 0;
    bus.bready = 1;
    n = 0;
    while (!bus.bvalid && n < 20) begin tick(); n++; end
    check("B_bvalid", {31'b0, bus.bvalid}, 1);
    check("B_frames", test_frame_num, 32'd10);
    tick();
    bus.bready = 0;

    // ---------------- ap_start / ap_ready ----------------
    ap_idle = 0;
    axi_write(6'h00, 32'd1, 4'b0001, resp);
    check("C_ap_start_set", {31'b0, ap_start}, 1);
    axi_read(6'h00, rd, resp);
    check("C_ctrl_started", rd, 32'h1);
    repeat (5) tick();
    ap_ready = 1; tick(); ap_ready = 0;
    check("C_ap_start_clr", {31'b0, ap_start}, 0);
    axi_read(6'h00, rd, resp);
    check("C_ctrl_cleared", rd, 32'h0);

    // Software set in the same cycle as ap_ready keeps ap_start high
    wait_wr_ready();
    bus.awaddr = 6'h00; bus.wdata = 32'd1; bus.wstrb = 4'b0001;
    bus.awvalid = 1; bus.wvalid = 1;
    tick();
    bus.awvalid = 0; bus.wvalid = 0;
    ap_ready = 1;
    tick();
    ap_ready = 0;
    check("C2_set_wins", {31'b0, ap_start}, 1);
    check("C2_bvalid", {31'b0, bus.bvalid}, 1);
    bus.bready = 1; tick(); bus.bready = 0;
    ap_ready = 1; tick(); ap_ready = 0;
    check("C2_clr_after", {31'b0, ap_start}, 0);

    // ---------------- ap_done / sticky / error_num ----------------
    ap_idle = 1; error_num_i = 32'd7; ap_done = 1;
    tick();
    ap_done = 0; error_num_i = 32'd0;
    axi_read(6'h00, rd, resp);
    check("D_ctrl_done", rd, 32'h6);
    axi_read(6'h00, rd, resp);
    check("D_ctrl_cleared", rd, 32'h4);
    axi_read(6'h10, rd, resp);
    check("D_err_num", rd, 32'd7);

    // ---------------- R stall, done during clearing read ----------------
    ap_idle = 0; error_num_i = 32'd9; ap_done = 1;
    tick();
    ap_done = 0;
    issue_ar(6'h00);
    rd0 = bus.rdata;
    check("E_rdata_first", rd0, 32'h2);
    ap_idle = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("E_rvalid_stall", {31'b0, bus.rvalid}, 1);
      check("E_rdata_stable", bus.rdata, 32'h2);
    end
    bus.rready = 1; ap_done = 1;
    tick();
    bus.rready = 0; ap_done = 0;
    check("E_rvalid_done", {31'b0, bus.rvalid}, 0);
    axi_read(6'h00, rd, resp);
    check("E_sticky_kept", rd, 32'h6);
    axi_read(6'h00, rd, resp);
    check("E_sticky_clr", rd, 32'h4);
    axi_read(6'h10, rd, resp);
    check("E_err_num", rd, 32'd9);

    // ---------------- table of write/read vectors ----------------
    vecs[0] = '{6'h10, 32'h0000FFFF, 4'hF, 32'd9,        32'd10,       32'd3742};
    vecs[1] = '{6'h3C, 32'hDEADBEEF, 4'hF, 32'd0,        32'd10,       32'd3742};
    vecs[2] = '{6'h04, 32'hFFFFFFFF, 4'hF, 32'd0,        32'd10,       32'd3742};
    vecs[3] = '{6'h0C, 32'h00000003, 4'hF, 32'd0,        32'd10,       32'd3742};
    vecs[4] = '{6'h28, 32'h11223344, 4'h8, 32'h11000E9E, 32'd10,       32'h11000E9E};
    vecs[5] = '{6'h20, 32'hAABBCCDD, 4'h5, 32'h00BB00DD, 32'h00BB00DD, 32'h11000E9E};
    vecs[6] = '{6'h28, 32'h00000000, 4'h0, 32'h11000E9E, 32'h00BB00DD, 32'h11000E9E};
    vecs[7] = '{6'h20, 32'h12345678, 4'hF, 32'h12345678, 32'h12345678, 32'h11000E9E};
    vecs[8] = '{6'h00, 32'hFFFFFFFE, 4'hF, 32'h4,        32'h12345678, 32'h11000E9E};
    vecs[9] = '{6'h00, 32'h00000001, 4'hE, 32'h4,        32'h12345678, 32'h11000E9E};
    ap_idle = 1;
    for (int i = 0; i < 10; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
      check("T_bresp", {30'b0, resp}, 0);
      check("T_frames", test_frame_num, vecs[i].exp_frames);
      check("T_offset", frame_offset, vecs[i].exp_offset);
      check("T_ap_start", {31'b0, ap_start}, 0);
      axi_read(vecs[i].addr, rd, resp);
      check("T_rresp", {30'b0, resp}, 0);
      check("T_rdata", rd, vecs[i].exp_rd);
    end

    // ---------------- reset while in RD_DATA ----------------
    issue_ar(6'h28);
    sync_rst_0 = 1;
    tick();
    sync_rst_0 = 0;
    check("G_rvalid_rst", {31'b0, bus.rvalid}, 0);
    check("G_rdata_rst", bus.rdata, 0);
    check("G_offset_rst", frame_offset, 0);
    check("G_frames_rst", test_frame_num, 0);
    bus.rready = 1;
    tick(); tick();
    bus.rready = 0;
    check("G_no_rvalid_after", {31'b0, bus.rvalid}, 0);
    check("G_no_bvalid_after", {31'b0, bus.bvalid}, 0);

    // ---------------- randomized run against the map model ----------------
    m_frames = 0; m_offset = 0; m_err = 0; m_sticky = 0; m_start = 0;
    for (int k = 0; k < 120; k++) begin
      ap_idle = 1'($urandom_range(0, 1));
      op = int'($urandom_range(0, 3));
      a = 6'($urandom_range(0, 15) * 4);
      if (op <= 1) begin
        wd = $urandom;
        st = 4'($urandom_range(0, 15));
        axi_write(a, wd, st, resp);
        if (a == 6'h20) m_frames = apply_strb(m_frames, wd, st);
        if (a == 6'h28) m_offset = apply_strb(m_offset, wd, st);
        if (a == 6'h00 && st[0] && wd[0]) m_start = 1;
        check("R_bresp", {30'b0, resp}, 0);
        check("R_frames", test_frame_num, m_frames);
        check("R_offset", frame_offset, m_offset);
        check("R_ap_start", {31'b0, ap_start}, {31'b0, m_start});
      end else if (op == 2) begin
        case (a)
          6'h00:   exp = {28'b0, 1'b0, ap_idle, m_sticky, m_start};
          6'h10:   exp = m_err;
          6'h20:   exp = m_frames;
          6'h28:   exp = m_offset;
          default: exp = 32'd0;
        endcase
        axi_read(a, rd, resp);
        if (a == 6'h00) m_sticky = 0;
        check("R_rdata", rd, exp);
        check("R_rresp", {30'b0, resp}, 0);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          error_num_i = $urandom;
          ap_done = 1; tick(); ap_done = 0;
          m_err = error_num_i; m_sticky = 1;
        end else begin
          ap_ready = 1; tick(); ap_ready = 0;
          m_start = 0;
          check("R_ready_clr", {31'b0, ap_start}, 0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
